// File: rtl/reg_bank8x16.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank8x16
//  Description : Eight-entry general-purpose register bank with a single
//                write port. Accepts NOP / WRITE / MOVE / two-cycle SWAP
//                commands and drives all eight registers out in parallel
//                to the downstream read multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd,
    input  logic [2:0]       dst,
    input  logic [2:0]       src,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R5,
    output logic [WIDTH-1:0] R6,
    output logic [WIDTH-1:0] R7
);

    localparam logic [1:0] c_CMD_NOP   = 2'b00;
    localparam logic [1:0] c_CMD_WRITE = 2'b01;
    localparam logic [1:0] c_CMD_MOVE  = 2'b10;
    localparam logic [1:0] c_CMD_SWAP  = 2'b11;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWAP2 = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_regs [0:7];
    logic [WIDTH-1:0] r_temp;
    logic [2:0]       r_src_lat;

    logic             w_we;
    logic [2:0]       w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_swap_start;

    // Single write port: choose address/data for this edge from state and command
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = dst;
        w_wdata      = wr_data;
        w_swap_start = 1'b0;
        if (r_state == c_ST_SWAP2) begin
            // Second half of a swap: live command inputs are ignored
            w_we    = 1'b1;
            w_waddr = r_src_lat;
            w_wdata = r_temp;
        end else begin
            case (cmd)
                c_CMD_WRITE: begin
                    w_we = 1'b1;
                end
                c_CMD_MOVE: begin
                    // src == dst rewrites the same value, so no net change
                    w_we    = 1'b1;
                    w_wdata = r_regs[src];
                end
                c_CMD_SWAP: begin
                    w_we         = 1'b1;
                    w_wdata      = r_regs[src];
                    w_swap_start = 1'b1;
                end
                c_CMD_NOP: begin
                    w_we = 1'b0;
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end
    end

    // Swap sequencer: capture displaced value and source index on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_temp    <= '0;
            r_src_lat <= '0;
        end else if (w_swap_start) begin
            r_state   <= c_ST_SWAP2;
            r_temp    <= r_regs[dst];
            r_src_lat <= src;
        end else begin
            r_state   <= c_ST_IDLE;
        end
    end

    // Register storage: at most one entry updated per edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    assign busy = (r_state == c_ST_SWAP2);

    assign R0 = r_regs[0];
    assign R1 = r_regs[1];
    assign R2 = r_regs[2];
    assign R3 = r_regs[3];
    assign R4 = r_regs[4];
    assign R5 = r_regs[5];
    assign R6 = r_regs[6];
    assign R7 = r_regs[7];

endmodule
`default_nettype wire
